alu_cmd_sequencer: RTL and testbench

- Command front-end for the tiny ALU. Accepts (A, B, op) commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's A/B/op/start pins, holding start until done, then captures result into a single-entry valid/ready response register.
- Enforces the ALU's protocol: one operation in flight, start held until done, one idle cycle between operations.

---
 rtl/alu_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue FSM in front of the tiny ALU, with a one-entry response register.
// Optional macro ALU_TIMEOUT_EN adds an ISSUE-state watchdog that aborts hung operations.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        illegal_op_seen,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("alu_cmd_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  // Entry layout: {op, a, b}
  logic [18:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  state_t      state_reg;

  logic [18:0] head;
  logic [2:0]  head_op;
  logic        fifo_empty, fifo_full, push;
  logic        head_legal, rsp_free, issue_now, drop_now;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign busy       = !fifo_empty || (state_reg != S_IDLE);

  assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign head_op    = head[18:16];
  assign head_legal = (head_op >= 3'b001) && (head_op <= 3'b100);
  assign rsp_free   = !rsp_valid || rsp_ready;

  // Issue from IDLE or straight out of GAP; no-op/illegal heads are only discarded in IDLE.
  assign issue_now = !fifo_empty && head_legal && rsp_free &&
                     ((state_reg == S_IDLE) || (state_reg == S_GAP));
  assign drop_now  = !fifo_empty && !head_legal && (state_reg == S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
    end else if (push) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_reg;
  logic          rsp_timeout_reg;
  assign rsp_timeout = rsp_timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_reg      <= '0;
      state_reg       <= S_IDLE;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_op          <= '0;
      alu_start       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_result      <= '0;
      rsp_op          <= '0;
      illegal_op_seen <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      to_cnt_reg      <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      // A response loaded later in this block overrides the clear.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (issue_now || drop_now) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop_now && head_op != 3'b000) begin
        illegal_op_seen <= 1'b1;
      end

      if (issue_now) begin
        alu_op    <= head_op;
        alu_a     <= head[15:8];
        alu_b     <= head[7:0];
        alu_start <= 1'b1;
        state_reg <= S_ISSUE;
`ifdef ALU_TIMEOUT_EN
        to_cnt_reg <= '0;
`endif
      end else begin
        case (state_reg)
          S_ISSUE: begin
            if (alu_done) begin
              rsp_result <= alu_result;
              rsp_op     <= alu_op;
              rsp_valid  <= 1'b1;
              alu_start  <= 1'b0;
              state_reg  <= S_GAP;
`ifdef ALU_TIMEOUT_EN
              rsp_timeout_reg <= 1'b0;
            end else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
              rsp_result      <= 16'h0000;
              rsp_op          <= alu_op;
              rsp_timeout_reg <= 1'b1;
              rsp_valid       <= 1'b1;
              alu_start       <= 1'b0;
              state_reg       <= S_GAP;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
`endif
            end
          end
          S_GAP:   state_reg <= S_IDLE;
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: behavioural ALU, response scoreboard, immediate-assert checks.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        illegal_op_seen;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [19:0] sb [$];   // {timeout, op, result}
  bit alu_hang = 1'b0;
  int alu_cyc = 0;

  alu_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .illegal_op_seen(illegal_op_seen), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  // Tiny ALU: done pulses after 1 start-cycle (mul: 4), then drops for one cycle.
  always @(posedge clk) begin
    if (alu_done) begin
      alu_done <= 1'b0;
      alu_cyc  <= 0;
    end else if (alu_start && !alu_hang) begin
      if (alu_cyc + 1 == ((alu_op == 3'b100) ? 4 : 1)) begin
        alu_done   <= 1'b1;
        alu_result <= alu_fn(alu_op, alu_a, alu_b);
      end
      alu_cyc <= alu_cyc + 1;
    end else if (!alu_start) begin
      alu_cyc <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed op %0d result %h, required no response", rsp_op, rsp_result);
      end
      if (sb.size() != 0) begin
        logic [19:0] exp;
        exp = sb.pop_front();
        $display("rsp: op=%0d result=%h timeout=%0d (expected op=%0d result=%h timeout=%0d)",
                 rsp_op, rsp_result, rsp_timeout, exp[18:16], exp[15:0], exp[19]);
        checks++;
        assert ({rsp_timeout, rsp_op, rsp_result} === exp) else begin
          errors++;
          $error("FAIL rsp_data: observed %h required %h", {rsp_timeout, rsp_op, rsp_result}, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Drives one command; returns 1ns after the write edge.
  task automatic push_raw(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("push_accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    $display("cmd: op=%0d a=%h b=%h", op, a, b);
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op >= 3'b001 && op <= 3'b100) sb.push_back({1'b0, op, alu_fn(op, a, b)});
    push_raw(op, a, b);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int cnt;
    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_abop", {alu_a, alu_b, alu_op}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_timeout, rsp_op, rsp_result}, 0);
    check("rst_illegal", illegal_op_seen, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    tick();

    // 1: add FF+01, latency E+1 start, E+3 response
    push(3'b001, 8'hFF, 8'h01);
    check("t1_start_pre", alu_start, 0);
    tick();
    check("t1_start", alu_start, 1);
    check("t1_operands", {alu_op, alu_a, alu_b}, {3'b001, 8'hFF, 8'h01});
    tick();
    check("t1_rsp_early", rsp_valid, 0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_result", rsp_result, 16'h0100);
    check("t1_rsp_op", rsp_op, 3'b001);
    check("t1_gap_start", alu_start, 0);
    tick();
    check("t1_rsp_cleared", rsp_valid, 0);

    // 2: mul 200*100, response at E+6, start high 4 cycles before done
    push(3'b100, 8'd200, 8'd100);
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (alu_start && !alu_done) cnt++;
    end
    check("t2_rsp_early", rsp_valid, 0);
    check("t2_start_cycles", cnt, 4);
    tick();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_result", rsp_result, 16'd20000);
    check("t2_gap_start", alu_start, 0);
    tick();
    check("t2_idle_start", alu_start, 0);
    check("t2_idle_busy", busy, 0);

    // 3: stall behind unaccepted response, fill FIFO, then drain in order
    rsp_ready = 1'b0;
    push(3'b011, 8'hAA, 8'h0F);
    push(3'b010, 8'h3C, 8'hF0);
    push(3'b001, 8'h7F, 8'h7F);
    push(3'b100, 8'h10, 8'h11);
    repeat (10) tick();
    check("t3_stall_start", alu_start, 0);
    check("t3_held_valid", rsp_valid, 1);
    check("t3_held_result", rsp_result, 16'h00A5);
    check("t3_busy", busy, 1);
    push(3'b011, 8'h12, 8'h34);
    check("t3_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    drain("t3_drain");
    tick(); tick();
    check("t3_busy_end", busy, 0);

    // 4: no-op and illegal are discarded silently
    push(3'b000, 8'h55, 8'h66);
    push(3'b110, 8'h77, 8'h88);
    push(3'b001, 8'h01, 8'h02);
    drain("t4_drain");
    check("t4_illegal", illegal_op_seen, 1);
    repeat (4) tick();
    check("t4_no_extra", rsp_valid, 0);

`ifdef ALU_TIMEOUT_EN
    // 5: hung ALU aborts after 15 ISSUE cycles
    alu_hang = 1'b1;
    sb.push_back({1'b1, 3'b100, 16'h0000});
    push_raw(3'b100, 8'd3, 8'd5);
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (alu_start) cnt++;
    end
    check("t5_issue_cycles", cnt, 15);
    check("t5_rsp_early", rsp_valid, 0);
    tick();
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_timeout", rsp_timeout, 1);
    check("t5_rsp_result", rsp_result, 16'h0000);
    check("t5_gap_start", alu_start, 0);
    tick();
    check("t5_idle_busy", busy, 0);
    alu_hang = 1'b0;
    drain("t5_drain");
`endif

    // 6: reset during mul ISSUE with queued commands
    push(3'b100, 8'd7, 8'd9);
    push(3'b001, 8'd1, 8'd1);
    push(3'b011, 8'hF0, 8'h0F);
    push(3'b010, 8'hFF, 8'h81);
    check("t6_in_issue", alu_start, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    check("t6_rst_start", alu_start, 0);
    check("t6_rst_abop", {alu_a, alu_b, alu_op}, 0);
    check("t6_rst_rsp", {rsp_valid, rsp_timeout, rsp_op, rsp_result}, 0);
    check("t6_rst_illegal", illegal_op_seen, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", cmd_ready, 1);
    repeat (20) tick();
    check("t6_quiet_rsp", rsp_valid, 0);
    check("t6_quiet_busy", busy, 0);
    check("t6_quiet_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
